// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, window base
// and the HWInt priority helper.
package int_ctrl_pkg;

  localparam logic [1:0] OFF_ACK  = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_PEND = 2'd2;
  localparam logic [1:0] OFF_EDGE = 2'd3;

  localparam logic [31:0] WIN_BASE = 32'h0000_7F20;
  localparam int          HWINT_W  = 6;

  // Lowest set bit index of the masked vector; 0 when nothing is set.
  function automatic logic [2:0] lowest_idx(input logic [HWINT_W-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = HWINT_W - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/int_src_cell.sv
// One interrupt source: sample register, edge/level set term and the pending latch.
module int_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic clear,
  output logic pending
);

  logic src_q;
  logic set;

  // src_q tracks src in both modes so a level->edge switch never fakes an edge.
  assign set = edge_mode ? (src & ~src_q) : src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~clear) | set;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: pending latches, mask, edge config,
// ID priority readback and the external-interrupt ACK pulse.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int              NSRC     = 4,
  parameter int              EXT_IDX  = 2,
  parameter logic [NSRC-1:0] EDGE_RST = 4'b0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel,
  input  logic [1:0]         addr,
  input  logic [3:0]         byteen,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NSRC-1:0]    src,
  output logic [HWINT_W-1:0] hwint,
  output logic               irq_any,
  output logic               ext_ack
);

  logic               wr;
  logic               wr_b0;
  logic [NSRC-1:0]    mask;
  logic [NSRC-1:0]    edge_mode;
  logic [NSRC-1:0]    pending;
  logic [NSRC-1:0]    clear;
  logic [HWINT_W-1:0] hw;
  logic               unused_wdata;

  assign wr           = sel & (|byteen);
  assign wr_b0        = wr & byteen[0];
  assign unused_wdata = ^wdata[31:NSRC];

  // ACK clears the external source on any byte lane; PENDING is write-1-to-clear.
  always_comb begin
    clear = '0;
    if (wr_b0 && addr == OFF_PEND) clear = wdata[NSRC-1:0];
    if (wr && addr == OFF_ACK)     clear[EXT_IDX] = 1'b1;
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    int_src_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .src       (src[i]),
      .edge_mode (edge_mode[i]),
      .clear     (clear[i]),
      .pending   (pending[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask      <= '1;
      edge_mode <= EDGE_RST;
      ext_ack   <= 1'b0;
    end else begin
      if (wr_b0 && addr == OFF_MASK) mask      <= wdata[NSRC-1:0];
      if (wr_b0 && addr == OFF_EDGE) edge_mode <= wdata[NSRC-1:0];
      ext_ack <= wr && (addr == OFF_ACK);
    end
  end

  always_comb begin
    hw           = '0;
    hw[NSRC-1:0] = pending & mask;
  end

  assign hwint   = hw;
  assign irq_any = |hw;

  // Reads are pure decode of the registers; sel does not gate them.
  always_comb begin
    rdata = '0;
    case (addr)
      OFF_ACK: begin
        rdata[31]  = |hw;
        rdata[2:0] = lowest_idx(hw);
      end
      OFF_MASK: rdata[NSRC-1:0] = mask;
      OFF_PEND: rdata[NSRC-1:0] = pending;
      OFF_EDGE: rdata[NSRC-1:0] = edge_mode;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed and randomized checks of int_ctrl against a per-source behavioural model.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int              NSRC     = 4;
  localparam int              EXT_IDX  = 2;
  localparam logic [NSRC-1:0] EDGE_RST = 4'b0100;

  logic               clk;
  logic               reset;
  logic               sel;
  logic [1:0]         addr;
  logic [3:0]         byteen;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic [NSRC-1:0]    src;
  logic [HWINT_W-1:0] hwint;
  logic               irq_any;
  logic               ext_ack;

  int total = 0;
  int bad   = 0;

  // Model state: one entry per source plus the two config registers.
  bit m_pend [NSRC];
  bit m_mask [NSRC];
  bit m_edge [NSRC];
  bit m_prev [NSRC];
  bit m_ack;

  int_ctrl #(.NSRC(NSRC), .EXT_IDX(EXT_IDX), .EDGE_RST(EDGE_RST)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .addr    (addr),
    .byteen  (byteen),
    .wdata   (wdata),
    .rdata   (rdata),
    .src     (src),
    .hwint   (hwint),
    .irq_any (irq_any),
    .ext_ack (ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 1'b0;
      m_mask[i] = 1'b1;
      m_edge[i] = EDGE_RST[i];
      m_prev[i] = 1'b0;
    end
    m_ack = 1'b0;
  endfunction

  function automatic logic [31:0] m_hwint();
    logic [31:0] v = 0;
    for (int i = 0; i < NSRC; i++) if (m_pend[i] && m_mask[i]) v += (1 << i);
    return v;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r = 0;
    case (a)
      0: begin
        for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) r = 32'h8000_0000 + i;
      end
      1: for (int i = 0; i < NSRC; i++) if (m_mask[i]) r += (1 << i);
      2: for (int i = 0; i < NSRC; i++) if (m_pend[i]) r += (1 << i);
      default: for (int i = 0; i < NSRC; i++) if (m_edge[i]) r += (1 << i);
    endcase
    return r;
  endfunction

  function automatic void m_update(input bit s, input int a, input logic [3:0] be,
                                   input logic [31:0] wd, input logic [NSRC-1:0] sv);
    bit is_wr = s && (be != 0);
    for (int i = 0; i < NSRC; i++) begin
      bit raised   = m_edge[i] ? (sv[i] && !m_prev[i]) : sv[i];
      bit cleared  = (is_wr && a == 2 && be[0] && wd[i]) || (is_wr && a == 0 && i == EXT_IDX);
      if (raised)       m_pend[i] = 1'b1;
      else if (cleared) m_pend[i] = 1'b0;
      m_prev[i] = sv[i];
    end
    if (is_wr && be[0] && a == 1) for (int i = 0; i < NSRC; i++) m_mask[i] = wd[i];
    if (is_wr && be[0] && a == 3) for (int i = 0; i < NSRC; i++) m_edge[i] = wd[i];
    m_ack = is_wr && a == 0;
  endfunction

  // One bus cycle: drive at the falling edge, check the read, clock it, check outputs.
  task automatic step(input bit s, input int a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [NSRC-1:0] sv);
    sel = s; addr = a[1:0]; byteen = be; wdata = wd; src = sv;
    #1;
    chk($sformatf("rdata@%0d", a), rdata, m_read(a));
    @(posedge clk);
    m_update(s, a, be, wd, sv);
    @(negedge clk);
    chk("hwint", 32'(hwint), m_hwint());
    chk("irq_any", 32'(irq_any), 32'(m_hwint() != 0));
    chk("ext_ack", 32'(ext_ack), 32'(m_ack));
  endtask

  task automatic idle(input logic [NSRC-1:0] sv);
    step(1'b0, 0, 4'h0, 32'h0, sv);
  endtask

  initial begin
    logic [NSRC-1:0] cur;
    reset = 1'b0; sel = 1'b0; addr = '0; byteen = '0; wdata = '0; src = '0;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset values of every register.
    for (int a = 0; a < 4; a++) step(1'b1, a, 4'h0, 32'h0, 4'h0);
    chk("rst_hwint", 32'(hwint), 32'h0);

    // External edge source, then ACK.
    repeat (4) idle(4'h0);
    idle(4'b0100);
    chk("edge_hwint", 32'(hwint), 32'h4);
    step(1'b1, 0, 4'h0, 32'h0, 4'b0100);
    chk("edge_id", rdata, 32'h8000_0002);
    step(1'b1, 0, 4'b0001, 32'h0, 4'h0);
    chk("ack_pulse", 32'(ext_ack), 32'h1);
    chk("ack_clear", 32'(hwint), 32'h0);
    idle(4'h0);
    chk("ack_once", 32'(ext_ack), 32'h0);

    // Level source cannot be cleared while held.
    idle(4'b0001);
    step(1'b1, 2, 4'b0001, 32'h1, 4'b0001);
    chk("lvl_hold", 32'(hwint), 32'h1);
    idle(4'h0);
    step(1'b1, 2, 4'b0001, 32'h1, 4'h0);
    chk("lvl_clear", 32'(hwint), 32'h0);

    // Mask and priority.
    idle(4'b1010);
    idle(4'h0);
    step(1'b1, 1, 4'b0001, 32'h8, 4'h0);
    chk("mask_hwint", 32'(hwint), 32'h8);
    step(1'b1, 0, 4'h0, 32'h0, 4'h0);
    chk("mask_id", rdata, 32'h8000_0003);
    step(1'b1, 1, 4'b0001, 32'hF, 4'h0);
    step(1'b1, 0, 4'h0, 32'h0, 4'h0);
    chk("prio_id", rdata, 32'h8000_0001);
    step(1'b1, 2, 4'b0001, 32'hF, 4'h0);

    // Rising edge and ACK in the same cycle: set wins, ack still pulses.
    step(1'b1, 0, 4'b0001, 32'h0, 4'b0100);
    chk("sim_pend", 32'(hwint), 32'h4);
    chk("sim_ack", 32'(ext_ack), 32'h1);
    step(1'b1, 2, 4'b0001, 32'hF, 4'h0);

    // Byte-enable gating on MASK.
    step(1'b1, 1, 4'b0010, 32'h0, 4'h0);
    step(1'b1, 1, 4'h0, 32'h0, 4'h0);
    chk("be_ignored", rdata, 32'hF);
    step(1'b1, 1, 4'b0001, 32'h0, 4'h0);
    chk("be_mask0", 32'(hwint), 32'h0);
    step(1'b1, 1, 4'b0001, 32'hF, 4'h0);

    // Asynchronous reset mid-cycle with pending=0101 and ext_ack high.
    step(1'b1, 0, 4'b0001, 32'h0, 4'b0101);
    chk("pre_rst_hw", 32'(hwint), 32'h5);
    sel = 1'b0; byteen = '0; src = '0; addr = 2'd1;
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("rst_hw_now", 32'(hwint), 32'h0);
    chk("rst_ack_now", 32'(ext_ack), 32'h0);
    chk("rst_mask", rdata, 32'h0000_000F);
    addr = 2'd3;
    #1;
    chk("rst_edge", rdata, 32'h0000_0004);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model.
    cur = '0;
    for (int n = 0; n < 600; n++) begin
      logic [3:0] be;
      be  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 3) == 0) cur = cur ^ NSRC'($urandom);
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), be, $urandom, cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller in the system bridge address window 0x7F20–0x7F2F.
- Collects NSRC peripheral interrupt lines (timer0, timer1, external interrupt, spare) into per-source pending latches.
- Applies a mask and drives the 6-bit HWInt vector consumed by CP0.
- A write to the ACK register (0x7F20) clears the external source and pulses ext_ack back to the interrupt generator.

Parameters:
- NSRC, 4, number of interrupt sources; range 1..6; source i maps to hwint[i].
- EXT_IDX, 2, index of the external-interrupt source cleared by the ACK write.
- EDGE_RST, 4'b0100, reset value of the EDGE config register (1 = rising-edge, 0 = level).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  bus access targets this block (address decoded upstream).
- addr  in  2  word offset in the window (bus address bits [3:2]).
- byteen  in  4  byte write enables; 4'b0000 = read.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from the registers.
- src  in  NSRC  raw interrupt lines, synchronous to clk.
- hwint  out  6  (pending & mask), zero-extended to 6 bits; to CP0.
- irq_any  out  1  OR of hwint.
- ext_ack  out  1  one-cycle pulse to the interrupt generator.

Behaviour:
- Reset (reset=0, async): pending=0, mask=all ones, edge=EDGE_RST, src_q=0, ext_ack=0. Therefore hwint=0, irq_any=0, rdata reflects the reset registers.
- Write condition: wr = sel & |byteen.
- Register map (only byte 0 is meaningful; writes need byteen[0] except ACK):
  - offset 0 ACK/ID
    - Read: bit31 = |(pending&mask); bits[2:0] = lowest index i with pending[i]&mask[i]; all other bits 0.
    - Write with any byteen: clears pending[EXT_IDX] and sets ext_ack=1 for the next cycle only.
  - offset 1 MASK, R/W, bits[NSRC-1:0].
  - offset 2 PENDING
    - Read: pending.
    - Write with byteen[0]: write-1-to-clear, pending &= ~wdata[NSRC-1:0].
  - offset 3 EDGE, R/W, per-source mode.
- Unwritten and unused bits read as 0.
- Source sampling, every cycle: src_q <= src.
  - Set term, edge mode: src & ~src_q.
  - Set term, level mode: src.
- Pending update at each clk edge: pending <= (pending & ~clear) | set.
  - Set wins over a simultaneous clear in the same cycle.
  - A level source therefore cannot be cleared while it is still asserted.
- Latency:
  - Edge mode: src rises in cycle N → pending and hwint high after edge N+1. hwint is combinational from the registers, so there is no extra stage.
  - MASK write at edge N → hwint changes after edge N.
- ext_ack is a registered pulse: ext_ack <= wr & (addr==0). Back-to-back ACK writes produce back-to-back pulses.
- Changing EDGE takes effect from the next edge. src_q is always tracked, so switching level→edge while src is high does not create an edge.
- Reads have no side effects.
- sel=0: no register changes; rdata is don't-care but must stay deterministic (still decoded from addr).
- hwint bits at index ≥ NSRC are tied 0.

Decomposition:
- Shared package holds:
  - register offsets: OFF_ACK=0, OFF_MASK=1, OFF_PEND=2, OFF_EDGE=3
  - window base 32'h7F20
  - HWInt width 6
- One natural sub-module, int_src_cell: per-source src_q, edge/level set logic and the pending bit. Instantiate NSRC times.
- The top level holds MASK, EDGE, the ID priority encoder, bus decode and ext_ack.

Test Plan:
- Reset → assert reset=0 mid-run with pending=4'b0101 → immediately hwint=0, ext_ack=0; read MASK=32'h0000000F, EDGE=32'h00000004.
- External edge + ACK:
  - Pulse src[2] 0→1 at cycle 10 → hwint=6'b000100 after edge 11; read ID=32'h80000002.
  - Write ACK (byteen=4'b0001) → ext_ack=1 for exactly one cycle; pending[2]=0.
- Level source persistence:
  - Hold src[0]=1 and write PENDING wdata=1 → pending[0] stays 1.
  - Drop src[0], then write again → pending[0]=0, hwint=0.
- Mask + priority:
  - Set pending=4'b1010 via sources, MASK=4'b1000 → hwint=6'b001000, ID=32'h80000003.
  - MASK=4'b1111 → ID=32'h80000001.
- Simultaneous events: in the same cycle, src[2] rises (edge mode) and an ACK write lands → pending[2]=1 after the edge (set wins), ext_ack still pulses.
- Byte-enable gating: write MASK with byteen=4'b0010, wdata=32'h0 → MASK unchanged at 4'hF; write with byteen=4'b0001 → MASK=0, hwint=0.
